// File: rtl/hamming_tx_encoder.sv
// SEC-DED Hamming (12,8) transmit encoder with overall parity bit 13.
// Each accepted byte becomes a 13-bit codeword that is held in parallel and shifted out LSB (position 1) first.
module hamming_tx_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data_in,
    input  logic        data_valid,
    input  logic [3:0]  err_pos,
    output logic        data_ready,
    output logic [13:1] code_out,
    output logic        serial_out,
    output logic        serial_valid,
    output logic        frame_start,
    output logic        busy,
    output logic [7:0]  frame_count
);

    // Handshake: a word transfers on any rising edge where data_valid and data_ready
    // are both high; data_ready is high in IDLE and in the position-13 cycle of a frame,
    // and the source must hold data_in/err_pos stable until that transfer happens.

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  bit_cnt;
    logic        accept;
    logic        last_bit;
    logic [13:1] code_clean;
    logic [13:1] err_mask;
    logic [13:1] code_next;

    assign last_bit = (bit_cnt == 4'd13);

    // Data bits occupy the non-power-of-two positions; parity bits fill 1, 2, 4 and 8.
    always_comb begin
        code_clean     = '0;
        code_clean[3]  = data_in[0];
        code_clean[5]  = data_in[1];
        code_clean[6]  = data_in[2];
        code_clean[7]  = data_in[3];
        code_clean[9]  = data_in[4];
        code_clean[10] = data_in[5];
        code_clean[11] = data_in[6];
        code_clean[12] = data_in[7];
        code_clean[1]  = code_clean[3] ^ code_clean[5] ^ code_clean[7] ^ code_clean[9] ^ code_clean[11];
        code_clean[2]  = code_clean[3] ^ code_clean[6] ^ code_clean[7] ^ code_clean[10] ^ code_clean[11];
        code_clean[4]  = code_clean[5] ^ code_clean[6] ^ code_clean[7] ^ code_clean[12];
        code_clean[8]  = code_clean[9] ^ code_clean[10] ^ code_clean[11] ^ code_clean[12];
        code_clean[13] = ^code_clean[12:1];
    end

    // Injection is applied after parity so the decoder sees a genuine single-bit error.
    always_comb begin
        err_mask = '0;
        if ((err_pos >= 4'd1) && (err_pos <= 4'd13)) begin
            err_mask[err_pos] = 1'b1;
        end
        code_next = code_clean ^ err_mask;
    end

    always_comb begin
        state_d    = state_q;
        data_ready = 1'b0;
        case (state_q)
            IDLE: begin
                data_ready = 1'b1;
                if (data_valid) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                data_ready = last_bit;
                if (last_bit && !data_valid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        accept = data_valid & data_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_out     <= '0;
            bit_cnt      <= '0;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            frame_start  <= 1'b0;
            frame_count  <= '0;
        end else begin
            frame_start <= accept;
            if (accept) begin
                code_out     <= code_next;
                bit_cnt      <= 4'd1;
                serial_out   <= code_next[1];
                serial_valid <= 1'b1;
                frame_count  <= frame_count + 8'd1;
            end else if ((state_q == SHIFT) && !last_bit) begin
                bit_cnt    <= 4'(bit_cnt + 4'd1);
                serial_out <= code_out[4'(bit_cnt + 4'd1)];
            end else if (state_q == SHIFT) begin
                bit_cnt      <= '0;
                serial_out   <= 1'b0;
                serial_valid <= 1'b0;
            end
        end
    end

    assign busy = serial_valid;

endmodule

// File: tb/tb_hamming_tx_encoder.sv
// Directed bench for hamming_tx_encoder: codeword values, serial framing,
// back-to-back streaming, asynchronous abort and frame counter wrap.
module tb_hamming_tx_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data_in;
    logic        data_valid;
    logic [3:0]  err_pos;
    logic        data_ready;
    logic [13:1] code_out;
    logic        serial_out;
    logic        serial_valid;
    logic        frame_start;
    logic        busy;
    logic [7:0]  frame_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hamming_tx_encoder dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .err_pos      (err_pos),
        .data_ready   (data_ready),
        .code_out     (code_out),
        .serial_out   (serial_out),
        .serial_valid (serial_valid),
        .frame_start  (frame_start),
        .busy         (busy),
        .frame_count  (frame_count)
    );

    task automatic apply_reset();
        rst        = 1'b1;
        data_valid = 1'b0;
        data_in    = '0;
        err_pos    = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Offers a word and returns 1 ns after the edge that accepted it.
    task automatic send_word(input logic [7:0] d, input logic [3:0] e);
        int waited;
        waited = 0;
        @(negedge clk);
        data_in    = d;
        err_pos    = e;
        data_valid = 1'b1;
        while ((data_ready !== 1'b1) && (waited < 40)) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (data_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_word_timeout: data_ready=%b expected 1", data_ready);
            data_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            data_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        data_valid = 1'b0;
        data_in    = '0;
        err_pos    = '0;
        #12;
        checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", data_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (code_out !== 13'h0000) begin errors++; $display("FAIL reset_code: got %h expected 0000", code_out); end
        checks++; if (serial_valid !== 1'b0) begin errors++; $display("FAIL reset_serial_valid: got %b expected 0", serial_valid); end
        checks++; if (serial_out !== 1'b0) begin errors++; $display("FAIL reset_serial_out: got %b expected 0", serial_out); end
        checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start: got %b expected 0", frame_start); end
        checks++; if (frame_count !== 8'd0) begin errors++; $display("FAIL reset_frame_count: got %0d expected 0", frame_count); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic_frame();
        logic [13:1] exp;
        logic [13:1] bits;
        exp  = 13'h0A27;
        bits = 13'b0_1010_0010_0111;
        apply_reset();
        send_word(8'hA5, 4'd0);
        checks++; if (code_out !== exp) begin errors++; $display("FAIL basic_code: got %h expected %h", code_out, exp); end
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            checks++; if (serial_out !== bits[4'(k)]) begin errors++; $display("FAIL basic_serial_pos%0d: got %b expected %b", k, serial_out, bits[4'(k)]); end
            checks++; if (frame_start !== (k == 1)) begin errors++; $display("FAIL basic_frame_start_pos%0d: got %b", k, frame_start); end
            checks++; if ((serial_valid !== 1'b1) || (busy !== 1'b1)) begin errors++; $display("FAIL basic_valid_pos%0d: serial_valid=%b busy=%b expected 1", k, serial_valid, busy); end
        end
        @(negedge clk);
        checks++; if (serial_valid !== 1'b0) begin errors++; $display("FAIL basic_end_valid: got %b expected 0", serial_valid); end
        checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL basic_end_ready: got %b expected 1", data_ready); end
        checks++; if (code_out !== exp) begin errors++; $display("FAIL basic_code_hold: got %h expected %h", code_out, exp); end
        checks++; if (frame_count !== 8'd1) begin errors++; $display("FAIL basic_count: got %0d expected 1", frame_count); end
    endtask

    task automatic test_patterns();
        logic [7:0]  vd [10];
        logic [3:0]  ve [10];
        logic [13:1] vc [10];
        vd = '{8'h00, 8'hFF, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hFF, 8'h01, 8'h80};
        ve = '{4'd0,  4'd0,  4'd5,  4'd13, 4'd15, 4'd14, 4'd1,  4'd12, 4'd0,  4'd0};
        vc = '{13'h0000, 13'h0F77, 13'h0A37, 13'h1A27, 13'h0A27,
               13'h0A27, 13'h0A26, 13'h0777, 13'h1007, 13'h1888};
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            send_word(vd[i], ve[i]);
            checks++; if (code_out !== vc[i]) begin errors++; $display("FAIL pattern_code_%0d: data=%h err=%0d got %h expected %h", i, vd[i], ve[i], code_out, vc[i]); end
            for (int k = 1; k <= 13; k++) begin
                @(negedge clk);
                checks++; if (serial_out !== vc[i][4'(k)]) begin errors++; $display("FAIL pattern_serial_%0d_pos%0d: got %b expected %b", i, k, serial_out, vc[i][4'(k)]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  w  [3];
        logic [13:1] cw [3];
        logic [3:0]  p;
        int          f;
        w  = '{8'hA5, 8'h00, 8'hFF};
        cw = '{13'h0A27, 13'h0000, 13'h0F77};
        apply_reset();
        @(negedge clk);
        data_in    = w[0];
        err_pos    = 4'd0;
        data_valid = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 39; c++) begin
            f = c / 13;
            p = 4'((c % 13) + 1);
            @(negedge clk);
            checks++; if (serial_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_c%0d: got %b expected 1", c, serial_valid); end
            checks++; if (frame_start !== (p == 4'd1)) begin errors++; $display("FAIL b2b_frame_start_c%0d: got %b", c, frame_start); end
            checks++; if (data_ready !== (p == 4'd13)) begin errors++; $display("FAIL b2b_ready_c%0d: got %b", c, data_ready); end
            checks++; if (serial_out !== cw[2'(f)][p]) begin errors++; $display("FAIL b2b_serial_c%0d: got %b expected %b", c, serial_out, cw[2'(f)][p]); end
            if (p == 4'd1) begin
                if (f < 2) data_in = w[2'(f + 1)];
                else data_valid = 1'b0;
            end
        end
        @(negedge clk);
        checks++; if ((serial_valid !== 1'b0) || (busy !== 1'b0)) begin errors++; $display("FAIL b2b_end_valid: serial_valid=%b busy=%b expected 0", serial_valid, busy); end
        checks++; if (frame_count !== 8'd3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", frame_count); end
        checks++; if (code_out !== 13'h0F77) begin errors++; $display("FAIL b2b_code_hold: got %h expected 0f77", code_out); end
    endtask

    task automatic test_async_reset();
        logic [13:1] bits;
        bits = 13'h0F77;
        apply_reset();
        send_word(8'hA5, 4'd0);
        repeat (7) @(negedge clk);
        checks++; if (serial_valid !== 1'b1) begin errors++; $display("FAIL abort_pre_valid: got %b expected 1", serial_valid); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (serial_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b expected 0", serial_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        checks++; if (code_out !== 13'h0000) begin errors++; $display("FAIL abort_code: got %h expected 0000", code_out); end
        checks++; if (frame_count !== 8'd0) begin errors++; $display("FAIL abort_count: got %0d expected 0", frame_count); end
        checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b expected 1", data_ready); end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (serial_valid !== 1'b0) begin errors++; $display("FAIL abort_quiet: got %b expected 0", serial_valid); end
        send_word(8'hFF, 4'd0);
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            checks++; if (serial_out !== bits[4'(k)]) begin errors++; $display("FAIL abort_next_serial_pos%0d: got %b expected %b", k, serial_out, bits[4'(k)]); end
            checks++; if (frame_start !== (k == 1)) begin errors++; $display("FAIL abort_next_start_pos%0d: got %b", k, frame_start); end
        end
        checks++; if (frame_count !== 8'd1) begin errors++; $display("FAIL abort_next_count: got %0d expected 1", frame_count); end
        @(negedge clk);
        checks++; if (serial_valid !== 1'b0) begin errors++; $display("FAIL abort_next_end: got %b expected 0", serial_valid); end
    endtask

    task automatic test_count_wrap();
        int waited;
        apply_reset();
        for (int i = 0; i < 255; i++) begin
            send_word(8'(i), 4'd0);
        end
        checks++; if (frame_count !== 8'd255) begin errors++; $display("FAIL wrap_count255: got %0d expected 255", frame_count); end
        @(negedge clk);
        data_in    = 8'h3C;
        err_pos    = 4'd0;
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (frame_count !== 8'd255) begin errors++; $display("FAIL wrap_midframe_count: got %0d expected 255", frame_count); end
        waited = 0;
        @(negedge clk);
        while ((data_ready !== 1'b1) && (waited < 40)) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (data_ready !== 1'b1) begin
            errors++;
            $display("FAIL wrap_ready_timeout: data_ready=%b expected 1", data_ready);
        end
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        checks++; if (frame_count !== 8'd0) begin errors++; $display("FAIL wrap_count0: got %0d expected 0", frame_count); end
        @(negedge clk);
        checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL wrap_frame_start: got %b expected 1", frame_start); end
        repeat (14) @(negedge clk);
        checks++; if (serial_valid !== 1'b0) begin errors++; $display("FAIL wrap_end_valid: got %b expected 0", serial_valid); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic_frame();
        test_patterns();
        test_back_to_back();
        test_async_reset();
        test_count_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hamming_tx_encoder.md
# hamming_tx_encoder

Transmit-side SEC-DED Hamming encoder that pairs with the 12-bit Hamming decoder. It accepts one 8-bit data word per valid/ready handshake and forms the 12-bit Hamming codeword plus an overall even-parity bit (13 bits total). It holds the codeword on a parallel output and shifts it out bit-serially, position 1 first. An optional single-bit error-injection field lets the bench exercise the decoder's correction path.

## Interface
- No parameters; all widths are fixed.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- data_in  input  8  data word, bits [8:1]
- data_valid  input  1  data_in and err_pos are valid
- err_pos  input  4  codeword position to invert (1..13); 0, 14 and 15 inject nothing
- data_ready  output  1  encoder can accept a word this cycle
- code_out  output  13  registered codeword [13:1]; bit 13 is the overall parity
- serial_out  output  1  current serial codeword bit
- serial_valid  output  1  serial_out is meaningful
- frame_start  output  1  one-cycle pulse on the first serial bit (position 1)
- busy  output  1  a frame is being shifted out
- frame_count  output  8  count of accepted words, wraps at 255

## Operation
- Codeword mapping:
  - Data positions: d1..d8 map to positions 3, 5, 6, 7, 9, 10, 11, 12.
  - Parity positions:
    - P1 = pos3^5^7^9^11
    - P2 = pos3^6^7^10^11
    - P4 = pos5^6^7^12
    - P8 = pos9^10^11^12
  - Bit 13 is the XOR of positions 1..12, so the 13-bit word has even parity.
- Error injection is applied after all parity bits are computed. When err_pos is in 1..13, exactly that bit is inverted in both code_out and the serial stream.
- States:
  - IDLE (reset state): data_ready=1, busy=0, serial_valid=0.
  - SHIFT: bit counter runs 1..13. serial_out is code_out[bit_cnt] and serial_valid=1.
- Transitions:
  - IDLE with data_valid=1: accept the word, load code_out, set bit_cnt=1, go to SHIFT.
  - SHIFT with bit_cnt<13: increment bit_cnt.
  - SHIFT with bit_cnt=13 and data_valid=1: accept the new word, reload code_out, set bit_cnt=1, stay in SHIFT.
  - SHIFT with bit_cnt=13 and data_valid=0: go to IDLE.
- data_ready = (state==IDLE) | (state==SHIFT & bit_cnt==13). The encoder never stalls a word offered at either of these points.
- Acceptance happens when data_valid & data_ready are both high at a clock edge. data_in and err_pos are sampled only at acceptance.
- frame_count increments by 1 on every acceptance and wraps from 255 to 0.
- code_out holds its value after the frame ends, until the next acceptance.

## Timing
- Reset (asynchronous, immediate) drives:
  - state=IDLE, data_ready=1, busy=0
  - code_out=0, serial_out=0, serial_valid=0, frame_start=0
  - frame_count=0, bit_cnt=0
- Reset during SHIFT aborts the frame with no further serial bits. The first acceptance after reset starts a fresh frame at position 1.
- Latency: acceptance at edge N makes code_out valid after edge N. In that cycle serial_out is position 1 and frame_start=1.
  - Position k is presented in cycle N+k.
  - The frame occupies exactly 13 consecutive cycles.
- Back-to-back: acceptance during the position-13 cycle makes the next cycle position 1 of the new frame. frame_start pulses again and there is no gap cycle.
- busy equals serial_valid; both are registered outputs.
- data_valid asserted while data_ready=0 is ignored. The word is neither lost nor counted; the source holds it until it is accepted.

## Test plan
- Reset, then offer data_in=8'hA5, err_pos=0:
  - code_out=13'h0A27.
  - Serial bits for positions 1..13 are 1,1,1,0,0,1,0,0,0,1,0,1,0.
  - frame_start pulses once; frame_count=1.
- Encode data_in=8'h00 and 8'hFF with err_pos=0 -> code_out=13'h0000 and 13'h0F77 respectively.
- data_in=8'hA5 with err_pos=5 -> code_out=13'h0A37. err_pos=13 -> 13'h1A27. err_pos=15 -> 13'h0A27.
- Hold data_valid high continuously over 3 words -> 39 contiguous serial_valid cycles, frame_start every 13 cycles, data_ready high only in each position-13 cycle.
- Assert rst asynchronously at position 7 of a frame:
  - All outputs return to their reset values immediately.
  - The next word produces a full 13-bit frame starting at position 1.
- Accept 256 words -> frame_count wraps to 0. A word offered mid-frame is not counted until its acceptance.
